// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access-size codes and FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Big-endian lane formatter: builds the extended load word and per-byte store lanes.
// Lane k always refers to byte address (aligned base + k).
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            sign_ext,
    input  logic [3:0][7:0] rd_bytes,
    input  logic [31:0]     data_i,
    output logic [31:0]     load_word,
    output logic [3:0]      byte_en,
    output logic [3:0][7:0] st_data
);

    always_comb begin
        load_word = '0;
        byte_en   = '0;
        st_data   = '0;
        case (size)
            SZ_BYTE: begin
                load_word  = {{24{sign_ext & rd_bytes[0][7]}}, rd_bytes[0]};
                byte_en    = 4'b0001;
                st_data[0] = data_i[7:0];
            end
            SZ_HALF: begin
                load_word  = {{16{sign_ext & rd_bytes[0][7]}}, rd_bytes[0], rd_bytes[1]};
                byte_en    = 4'b0011;
                st_data[0] = data_i[15:8];
                st_data[1] = data_i[7:0];
            end
            // Reserved size behaves as a word here; the top suppresses it when checking is on.
            default: begin
                load_word  = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
                byte_en    = 4'b1111;
                st_data[0] = data_i[31:24];
                st_data[1] = data_i[23:16];
                st_data[2] = data_i[15:8];
                st_data[3] = data_i[7:0];
            end
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed big-endian data memory with configurable latency and req/ready handshake.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned/reserved accesses on err.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] byte_addr,
    input  logic [31:0]       data_i,
    output logic [31:0]       out,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t       state, state_nxt;
    logic [3:0]        cnt;
    logic              we_q, sign_ext_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [7:0]        mem [DEPTH];

    logic              accept, complete, bad;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] lane_addr [4];
    logic [3:0][7:0]   rd_bytes, st_data;
    logic [3:0]        byte_en;
    logic [31:0]       load_word;

    assign accept   = req && (state != WAIT);
    assign complete = (state == WAIT) && (cnt == 4'd0);
    assign busy     = (state == WAIT);
    assign ready    = (state == DONE);

    always_comb begin
        base = addr_q;
        case (size_q)
            SZ_BYTE: base = addr_q;
            SZ_HALF: base[0] = 1'b0;
            default: base[1:0] = 2'b00;
        endcase
    end

    // Lane addresses wrap inside the array; only lanes enabled by size are ever used.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = base + ADDR_W'(k);
            rd_bytes[k]  = mem[lane_addr[k]];
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad = ((size_q == SZ_HALF) && addr_q[0])
              || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
              || (size_q == SZ_RSVD);
`else
    assign bad = 1'b0;
`endif

    dmem_lane_fmt u_lane_fmt (
        .size      (size_q),
        .sign_ext  (sign_ext_q),
        .rd_bytes  (rd_bytes),
        .data_i    (data_q),
        .load_word (load_word),
        .byte_en   (byte_en),
        .st_data   (st_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = req ? WAIT : IDLE;
            WAIT:       if (cnt == 4'd0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt        <= CNT_INIT;
                we_q       <= we;
                sign_ext_q <= sign_ext;
                size_q     <= size;
                addr_q     <= byte_addr;
                data_q     <= data_i;
            end else if (busy && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // err is only ever set on the completion edge, so it is high exactly while ready is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
            err <= 1'b0;
        end else if (complete) begin
            err <= bad;
            out <= (we_q || bad) ? 32'd0 : load_word;
        end else begin
            err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
        end else if (complete && we_q && !bad) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[lane_addr[k]] <= st_data[k];
            end
        end
    end

endmodule

// File: tb/tb_dmem_sized.sv
// Self-checking bench for dmem_sized: LATENCY=1 unit driven from a vector table,
// LATENCY=3 unit exercised with hand-written timing sequences.
module tb_dmem_sized;
    import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ACHK = 1'b1;
`else
    localparam bit ACHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  req, we, sx;
    logic [1:0]  size [2];
    logic [5:0]  addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic [1:0]  ready, busy, err;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sx;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [31:0] e_out;
        logic        e_err;
    } vec_t;

    vec_t vec [19];

    dmem_sized #(.DEPTH(64), .LATENCY(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .size(size[0]),
        .sign_ext(sx[0]), .byte_addr(addr[0]), .data_i(din[0]), .out(dout[0]),
        .ready(ready[0]), .busy(busy[0]), .err(err[0])
    );

    dmem_sized #(.DEPTH(64), .LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .size(size[1]),
        .sign_ext(sx[1]), .byte_addr(addr[1]), .data_i(din[1]), .out(dout[1]),
        .ready(ready[1]), .busy(busy[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pops one expected {err, out} record.
    always @(negedge clk) begin
        if (rst_n && ready[0]) begin
            if (exp_q0.size() == 0) check("u0_unexpected_ready", 33'd1, 33'd0);
            else check("u0_result", {err[0], dout[0]}, exp_q0.pop_front());
        end
        if (rst_n && ready[1]) begin
            if (exp_q1.size() == 0) check("u1_unexpected_ready", 33'd1, 33'd0);
            else check("u1_result", {err[1], dout[1]}, exp_q1.pop_front());
        end
    end

    task automatic do_access(input int u, input logic w, input logic [1:0] sz, input logic s,
                             input logic [5:0] a, input logic [31:0] d,
                             input logic [31:0] e_out, input logic e_err, input int lat);
        @(negedge clk);
        if (u == 0) exp_q0.push_back({e_err, e_out});
        else        exp_q1.push_back({e_err, e_out});
        req[u] = 1'b1; we[u] = w; size[u] = sz; sx[u] = s; addr[u] = a; din[u] = d;
        @(posedge clk);
        #1 req[u] = 1'b0;
        check("busy_after_accept", {32'd0, busy[u]}, 33'd1);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k < lat) begin
                check("busy_in_wait", {32'd0, busy[u]}, 33'd1);
                check("no_early_ready", {32'd0, ready[u]}, 33'd0);
            end else begin
                check("ready_on_time", {32'd0, ready[u]}, 33'd1);
                check("busy_low_in_done", {32'd0, busy[u]}, 33'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; sx = '0;
        for (int u = 0; u < 2; u++) begin
            size[u] = SZ_BYTE; addr[u] = '0; din[u] = '0;
        end

        vec[0]  = '{1'b0, SZ_WORD, 1'b0, 6'h04, 32'h0,        32'h04050607, 1'b0};
        vec[1]  = '{1'b1, SZ_BYTE, 1'b0, 6'h09, 32'h00000085, 32'h0,        1'b0};
        vec[2]  = '{1'b0, SZ_BYTE, 1'b1, 6'h09, 32'h0,        32'hFFFFFF85, 1'b0};
        vec[3]  = '{1'b0, SZ_BYTE, 1'b0, 6'h09, 32'h0,        32'h00000085, 1'b0};
        vec[4]  = '{1'b1, SZ_HALF, 1'b0, 6'h02, 32'h0000BEEF, 32'h0,        1'b0};
        vec[5]  = '{1'b0, SZ_WORD, 1'b0, 6'h00, 32'h0,        32'h0001BEEF, 1'b0};
        vec[6]  = '{1'b0, SZ_WORD, 1'b0, 6'h06, 32'h0,        ACHK ? 32'h0 : 32'h04050607, ACHK};
        vec[7]  = '{1'b1, SZ_HALF, 1'b1, 6'h10, 32'hFFFF8001, 32'h0,        1'b0};
        vec[8]  = '{1'b0, SZ_HALF, 1'b1, 6'h10, 32'h0,        32'hFFFF8001, 1'b0};
        vec[9]  = '{1'b0, SZ_HALF, 1'b0, 6'h10, 32'h0,        32'h00008001, 1'b0};
        vec[10] = '{1'b0, SZ_WORD, 1'b0, 6'h3C, 32'h0,        32'h3C3D3E3F, 1'b0};
        vec[11] = '{1'b0, SZ_BYTE, 1'b1, 6'h3F, 32'h0,        32'h0000003F, 1'b0};
        vec[12] = '{1'b1, SZ_WORD, 1'b0, 6'h20, 32'h12345678, 32'h0,        1'b0};
        vec[13] = '{1'b0, SZ_BYTE, 1'b0, 6'h22, 32'h0,        32'h00000056, 1'b0};
        vec[14] = '{1'b0, SZ_HALF, 1'b1, 6'h21, 32'h0,        ACHK ? 32'h0 : 32'h00001234, ACHK};
        vec[15] = '{1'b0, SZ_RSVD, 1'b0, 6'h0C, 32'h0,        ACHK ? 32'h0 : 32'h0C0D0E0F, ACHK};
        vec[16] = '{1'b0, SZ_WORD, 1'b0, 6'h08, 32'h0,        32'h08850A0B, 1'b0};
        vec[17] = '{1'b1, SZ_HALF, 1'b0, 6'h05, 32'h0000AAAA, 32'h0,        ACHK};
        vec[18] = '{1'b0, SZ_WORD, 1'b0, 6'h04, 32'h0,        ACHK ? 32'h04050607 : 32'hAAAA0607, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("rst_out",   {1'b0, dout[u]}, 33'd0);
            check("rst_ready", {32'd0, ready[u]}, 33'd0);
            check("rst_busy",  {32'd0, busy[u]}, 33'd0);
            check("rst_err",   {32'd0, err[u]}, 33'd0);
        end

        for (int i = 0; i < 19; i++)
            do_access(0, vec[i].we, vec[i].size, vec[i].sx, vec[i].addr, vec[i].data,
                      vec[i].e_out, vec[i].e_err, 1);

        // LATENCY=3: two back-to-back loads, the second accepted while in DONE.
        do_access(1, 1'b0, SZ_WORD, 1'b0, 6'h04, 32'h0, 32'h04050607, 1'b0, 3);
        do_access(1, 1'b0, SZ_WORD, 1'b0, 6'h08, 32'h0, 32'h08090A0B, 1'b0, 3);

        // A store request held high through WAIT must be ignored entirely.
        @(negedge clk);
        exp_q1.push_back({1'b0, 32'h00010203});
        req[1] = 1'b1; we[1] = 1'b0; size[1] = SZ_WORD; sx[1] = 1'b0; addr[1] = 6'h00;
        @(posedge clk);
        #1 we[1] = 1'b1; din[1] = 32'hAAAAAAAA;
        repeat (3) @(posedge clk);
        #1 req[1] = 1'b0;
        check("wait_req_done", {32'd0, ready[1]}, 33'd1);
        do_access(1, 1'b0, SZ_WORD, 1'b0, 6'h00, 32'h0, 32'h00010203, 1'b0, 3);

        // Reset mid-WAIT discards the pending store.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; size[1] = SZ_WORD; addr[1] = 6'h08; din[1] = 32'hDEADBEEF;
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {32'd0, busy[1]}, 33'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy",  {32'd0, busy[1]}, 33'd0);
        check("post_rst_ready", {32'd0, ready[1]}, 33'd0);
        do_access(1, 1'b0, SZ_WORD, 1'b0, 6'h08, 32'h0, 32'h08090A0B, 1'b0, 3);
        do_access(0, 1'b0, SZ_WORD, 1'b0, 6'h08, 32'h0, 32'h08090A0B, 1'b0, 1);

        repeat (3) @(negedge clk);
        check("u0_queue_drained", {1'b0, 32'(exp_q0.size())}, 33'd0);
        check("u1_queue_drained", {1'b0, 32'(exp_q1.size())}, 33'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised, clocked byte-addressed data memory for the single-cycle MIPS CPU, supporting byte, halfword and word loads and stores with optional sign extension. Access latency is configurable, and completion is signalled with a request/ready handshake. Storage is big-endian and sits on the datapath's load/store path behind the ALU address output.

## Interface
Parameters:
- DEPTH, 64: memory size in bytes; power of two, ≥ 4.
- ADDR_W, $clog2(DEPTH): byte-address width.
- LATENCY, 1: cycles from request accept to completion; legal range 1..15.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  1  access request; sampled at a rising edge when the block is not busy.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- sign_ext  in  1  loads only; 1 = sign-extend byte/halfword, 0 = zero-extend.
- byte_addr  in  ADDR_W  byte address.
- data_i  in  32  store data, right-justified.
- out  out  32  load result; registered.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while an access is in flight; req is ignored while high.
- err  out  1  misaligned or reserved-size access flag; valid with ready.

## Operation
- States:
  - IDLE: no access in flight.
  - WAIT: down-counter cnt (4 bits) is running.
  - DONE: ready = 1 for this one cycle.
- State transitions:
  - IDLE or DONE with req = 1: capture we, size, sign_ext, byte_addr and data_i; load cnt = LATENCY-1; go to WAIT.
  - IDLE or DONE with req = 0: go to IDLE.
  - WAIT with cnt ≠ 0: decrement cnt.
  - WAIT with cnt = 0: perform the access at this edge, then go to DONE.
- Outputs by state:
  - busy = (state == WAIT).
  - ready = (state == DONE).
- Array contents after reset: memory[i] = i[7:0].
- Byte order is big-endian: the lowest address holds the most significant byte.
- Loads:
  - Byte: out = ext(mem[a]).
  - Halfword: out = ext({mem[a], mem[a+1]}).
  - Word: out = {mem[a], …, mem[a+3]}.
  - ext() sign- or zero-extends according to the captured sign_ext.
- Stores:
  - Byte writes data_i[7:0].
  - Halfword writes data_i[15:0].
  - Word writes data_i[31:0].
  - out is cleared to 0 when a store completes.
- Aligned address a:
  - Halfword: byte_addr with bit 0 cleared.
  - Word: byte_addr with bits 1:0 cleared.
  - Byte: byte_addr unchanged.
- Addresses are ADDR_W bits wide, so an access can never leave the array.
- out holds its value between completions.

## Timing
- req high at edge N (block not busy) → access takes effect at edge N+LATENCY → ready high for the following cycle.
- Throughput: one access per LATENCY+1 cycles.
- A request accepted while in DONE starts immediately; there is no bubble.
- Loads read array contents as they stand before the completion edge.
- req during WAIT: ignored, not queued.
- Reset outputs: out = 0, ready = 0, busy = 0, err = 0; state = IDLE; array reinitialised.
- Reset asserted in WAIT: the pending access is discarded and its store is not written.
- err pulses only together with ready.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A halfword access with byte_addr[0] = 1, a word access with byte_addr[1:0] ≠ 0, or size = 11 completes with err = 1 and out = 0.
  - No array write occurs for that access.
- DMEM_ALIGN_CHECK_EN undefined:
  - err is tied to 0.
  - Misaligned addresses are silently aligned as described under Operation.
  - size = 11 is treated as word.

## Structure
- Package dmem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - The state enum dmem_state_t (IDLE, WAIT, DONE).
- Sub-module dmem_lane_fmt (combinational) takes size, sign_ext and the four fetched bytes and produces the extended load word and per-byte store enables/data.
- The top level holds the FSM, counter, capture registers and array.

## Test plan
- LATENCY = 1, after reset: lw at 0x04 → ready one cycle after the accept cycle, out = 0x04050607, err = 0.
- Byte sign extension: sb 0x85 at 0x09, then lb signed at 0x09 → 0xFFFFFF85; lbu at 0x09 → 0x00000085.
- Halfword store: sh 0xBEEF at 0x02, then lw at 0x00 → 0x0001BEEF; a store completion drives out = 0.
- Misaligned word load lw at 0x06:
  - With DMEM_ALIGN_CHECK_EN: err = 1, out = 0, memory unchanged.
  - Without it: out = 0x04050607.
- LATENCY = 3:
  - ready occurs exactly 3 edges after accept.
  - busy is high for 3 cycles.
  - req pulses during WAIT are ignored.
  - A back-to-back req in DONE is accepted with no idle cycle.
- Reset mid-WAIT during sw 0xDEADBEEF at 0x08: afterwards busy = 0, and lw at 0x08 → 0x08090A0B.
